// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit slice.
package nibble_add_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Nibble counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (clog2(nib) < 1) ? 1 : clog2(nib);
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// Purely combinational 4-bit ripple-carry adder slice.
module ripple_adder
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] sum_c,
  output logic             co_c
);

  logic carry;

  // Ripple the carry through each bit position, LSB first.
  always_comb begin
    sum_c = '0;
    carry = ci;
    for (int i = 0; i < int'(NIB_W); i++) begin
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co_c = carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice for WIDTH/4 cycles per operation.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             co,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = cnt_width(NIB);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               c_r_q, c_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [NIB_W-1:0]   slice_sum_c;
  logic               slice_co_c;

  // Single shared slice: always fed from the low nibble of the operand shifters.
  ripple_adder U0 (
    .a     (a_sh_q[NIB_W-1:0]),
    .b     (b_sh_q[NIB_W-1:0]),
    .ci    (c_r_q),
    .sum_c (slice_sum_c),
    .co_c  (slice_co_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_r_d   = c_r_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = A;
          b_sh_d  = B;
          c_r_d   = ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> NIB_W;
        b_sh_d = b_sh_q >> NIB_W;
        // Completed nibbles enter at the MSB end so the LSB nibble lands at bit 0 last.
        s_sh_d = (s_sh_q >> NIB_W) | (WIDTH'(slice_sum_c) << (WIDTH - NIB_W));
        c_r_d  = slice_co_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered, so derive them from the state being entered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_sh_q      <= '0;
      c_r_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      s_sh_q      <= s_sh_d;
      c_r_q       <= c_r_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign SUM       = s_sh_q;
  assign co        = c_r_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16 main instance, WIDTH=4 corner instance).
module tb_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned W1  = W + 1;
  localparam int          NIB = 4;

  logic          clk = 1'b0;
  logic          rst;

  logic          in_valid, in_ready, ci_in, out_valid, out_ready, co_o, busy_o;
  logic [W-1:0]  a_in, b_in, sum_o;

  logic          in_valid4, in_ready4, ci4, out_valid4, out_ready4, co4, busy4;
  logic [3:0]    a4, b4, sum4;

  int            checks   = 0;
  int            failures = 0;
  logic [W:0]    sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .ci        (ci_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (sum_o),
    .co        (co_o),
    .busy      (busy_o)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .A         (a4),
    .B         (b4),
    .ci        (ci4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .SUM       (sum4),
    .co        (co4),
    .busy      (busy4)
  );

  // Present one operand set on the 16-bit DUT; returns on the negedge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_wait in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    ci_in    = c;
    sb.push_back(W1'(a) + W1'(b) + W1'(c));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall, compare against the scoreboard, complete the handshake.
  task automatic recv(input int stall, input bit chk_lat);
    int          lat = 0;
    logic [W:0]  expv;
    logic [W-1:0] s0;
    logic        c0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL recv_timeout out_valid=%b required=1", out_valid);
      sb.delete();
      return;
    end
    if (chk_lat) begin
      checks++;
      if (lat !== NIB) begin
        failures++;
        $display("FAIL latency got=%0d required=%0d", lat, NIB);
      end
    end
    s0 = sum_o;
    c0 = co_o;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sum_o !== s0 || co_o !== c0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold ov=%b sum=%h co=%b rdy=%b required ov=1 sum=%h co=%b rdy=0",
                 out_valid, sum_o, co_o, in_ready, s0, c0);
      end
    end
    expv = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++;
    if ({c0, s0} !== expv) begin
      failures++;
      $display("FAIL result co_sum=%h required=%h", {c0, s0}, expv);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; ci_in = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum_o, co_o, busy_o} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset rdy=%b ov=%b sum=%h co=%b busy=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum_o, co_o, busy_o);
    end
    checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100) begin
      failures++;
      $display("FAIL reset4 rdy=%b ov=%b busy=%b required 1 0 0", in_ready4, out_valid4, busy4);
    end
  endtask

  task automatic test_basic();
    send(16'h1234, 16'h4321, 1'b0);
    checks++;
    if (busy_o !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_flags busy=%b in_ready=%b required 1/0", busy_o, in_ready);
    end
    recv(0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1); recv(0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1); recv(0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0); recv(0, 1'b1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 1'b0);
    out_ready = 1'b1;
    recv(0, 1'b1);
    send(16'h0FFF, 16'h0001, 1'b0);
    out_ready = 1'b1;
    recv(0, 1'b1);
  endtask

  task automatic test_backpressure();
    int          t = 0;
    logic [W:0]  expv;
    logic [W-1:0] s0;
    logic        c0;
    send(16'h1111, 16'h2222, 1'b1);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    s0 = sum_o;
    c0 = co_o;
    in_valid = 1'b1; a_in = 16'hABCD; b_in = 16'h1234; ci_in = 1'b1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sum_o !== s0 || co_o !== c0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold ov=%b sum=%h co=%b rdy=%b required 1 %h %b 0",
                 out_valid, sum_o, co_o, in_ready, s0, c0);
      end
    end
    expv = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++;
    if ({c0, s0} !== expv) begin
      failures++;
      $display("FAIL bp_result co_sum=%h required=%h", {c0, s0}, expv);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release ov=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    sb.push_back(W1'(16'hABCD) + W1'(16'h1234) + W1'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept busy=%b rdy=%b required 1/0", busy_o, in_ready);
    end
    recv(0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    send(16'h00FF, 16'h0F0F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({in_ready, out_valid, sum_o, co_o, busy_o} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset rdy=%b ov=%b sum=%h co=%b busy=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum_o, co_o, busy_o);
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL discarded_op out_valid_seen=%b required=0", seen);
    end
    send(16'h0001, 16'h0001, 1'b0);
    recv(1, 1'b1);
  endtask

  task automatic test_width4();
    logic [3:0] va[3] = '{4'h9, 4'hF, 4'h3};
    logic [3:0] vb[3] = '{4'h8, 4'hF, 4'h4};
    logic       vc[3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0] expv;
    int         lat;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      expv = 5'(va[k]) + 5'(vb[k]) + 5'(vc[k]);
      in_valid4 = 1'b1; a4 = va[k]; b4 = vb[k]; ci4 = vc[k];
      @(negedge clk);
      in_valid4 = 1'b0;
      while (!out_valid4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1 || {co4, sum4} !== expv) begin
        failures++;
        $display("FAIL w4 lat=%0d co_sum=%h required lat=1 co_sum=%h", lat, {co4, sum4}, expv);
      end
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
        failures++;
        $display("FAIL w4_release ov=%b rdy=%b required 0/1", out_valid4, in_ready4);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      recv(int'($urandom_range(0, 3)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time_limit reached required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
